// File: rtl/adder_bist_pkg.sv
// Shared types for the adder BIST controller.
package adder_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } bist_state_t;

endpackage

// File: rtl/adder_bist_controller_if.sv
// Operand/result/status bundle between the BIST controller and its surroundings.
interface adder_bist_controller_if #(
  parameter int unsigned NBITS = 16,
  parameter int unsigned ERR_W = 32
);
  logic             start;
  logic [NBITS-1:0] a_out;
  logic [NBITS-1:0] b_out;
  logic             cin_out;
  logic [NBITS-1:0] sum_in;
  logic             cout_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [NBITS-1:0] first_err_a;
  logic [NBITS-1:0] first_err_b;
  logic             first_err_cin;

  modport master (
    input  start, sum_in, cout_in,
    output a_out, b_out, cin_out, busy, done, pass, err_pulse, err_count,
           first_err_a, first_err_b, first_err_cin
  );

  modport slave (
    output start, sum_in, cout_in,
    input  a_out, b_out, cin_out, busy, done, pass, err_pulse, err_count,
           first_err_a, first_err_b, first_err_cin
  );
endinterface

// File: rtl/bist_operand_counter.sv
// {cin,a,b} vector counter: b innermost, then a, then cin; flags the all-ones last vector.
module bist_operand_counter #(
  parameter int unsigned NBITS = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             advance_i,
  output logic [NBITS-1:0] a_o,
  output logic [NBITS-1:0] b_o,
  output logic             cin_o,
  output logic             last_o
);

  localparam int unsigned VecW = 2 * NBITS + 1;

  logic [VecW-1:0] vec_q, vec_d;

  always_comb begin
    vec_d = vec_q;
    if (clear_i) begin
      vec_d = '0;
    end else if (advance_i) begin
      vec_d = vec_q + VecW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vec_q <= '0;
    end else begin
      vec_q <= vec_d;
    end
  end

  // Plain binary increment gives exactly the b -> a -> cin carry order.
  assign {cin_o, a_o, b_o} = vec_q;
  assign last_o            = &vec_q;

endmodule

// File: rtl/adder_bist_controller.sv
// Exhaustive self-test driver/checker for an NBITS adder: sweeps all {cin,a,b} and checks sums.
module adder_bist_controller
  import adder_bist_pkg::*;
#(
  parameter int unsigned NBITS         = 16,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned ERR_W         = 32
) (
  input logic                   clk,
  input logic                   reset_n,
  adder_bist_controller_if.master bus
);

  localparam int unsigned SetW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  bist_state_t      state_q, state_d;
  logic [SetW-1:0]  settle_q, settle_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [NBITS-1:0] first_a_q, first_a_d;
  logic [NBITS-1:0] first_b_q, first_b_d;
  logic             first_cin_q, first_cin_d;
  logic             err_pulse_q, err_pulse_d;

  logic             clear, advance, last;
  logic [NBITS-1:0] a, b;
  logic             cin;
  logic [NBITS:0]   expected;
  logic             miscompare;

  bist_operand_counter #(
    .NBITS(NBITS)
  ) u_operand_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear_i  (clear),
    .advance_i(advance),
    .a_o      (a),
    .b_o      (b),
    .cin_o    (cin),
    .last_o   (last)
  );

  assign expected   = {1'b0, a} + {1'b0, b} + {{NBITS{1'b0}}, cin};
  assign miscompare = ({bus.cout_in, bus.sum_in} != expected);

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    err_count_d = err_count_q;
    first_a_d   = first_a_q;
    first_b_d   = first_b_q;
    first_cin_d = first_cin_q;
    err_pulse_d = 1'b0;
    clear       = 1'b0;
    advance     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d     = APPLY;
          settle_d    = '0;
          clear       = 1'b1;
          err_count_d = '0;
          first_a_d   = '0;
          first_b_d   = '0;
          first_cin_d = 1'b0;
        end
      end
      APPLY: begin
        if (settle_q == SetW'(SETTLE_CYCLES - 1)) begin
          state_d  = CHECK;
          settle_d = '0;
        end else begin
          settle_d = settle_q + SetW'(1);
        end
      end
      CHECK: begin
        if (miscompare) begin
          err_pulse_d = 1'b1;
          if (err_count_q != '1) begin
            err_count_d = err_count_q + ERR_W'(1);
          end
          if (err_count_q == '0) begin
            first_a_d   = a;
            first_b_d   = b;
            first_cin_d = cin;
          end
        end
        // Operands hold the last vector once the sweep finishes.
        if (last) begin
          state_d = DONE;
        end else begin
          state_d = APPLY;
          advance = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      settle_q    <= '0;
      err_count_q <= '0;
      first_a_q   <= '0;
      first_b_q   <= '0;
      first_cin_q <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      err_count_q <= err_count_d;
      first_a_q   <= first_a_d;
      first_b_q   <= first_b_d;
      first_cin_q <= first_cin_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign bus.a_out         = a;
  assign bus.b_out         = b;
  assign bus.cin_out       = cin;
  assign bus.busy          = (state_q == APPLY) || (state_q == CHECK);
  assign bus.done          = (state_q == DONE);
  assign bus.pass          = (state_q == DONE) && (err_count_q == '0);
  assign bus.err_pulse     = err_pulse_q;
  assign bus.err_count     = err_count_q;
  assign bus.first_err_a   = first_a_q;
  assign bus.first_err_b   = first_b_q;
  assign bus.first_err_cin = first_cin_q;

endmodule

// File: tb/tb_adder_bist_controller.sv
// Scoreboard bench: three 4-bit BIST instances driving behavioural adders, some with faults.
module tb_adder_bist_controller;

  typedef struct {
    int cycles;
    int errs;
    int pulses;
    int fa;
    int fb;
    int fcin;
    int pass;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   mode_a = 0;  // 0 good adder, 1 sum[0] stuck 0, 2 cout stuck 0
  int   st_a = 0, st_b = 0, st_c = 0;
  int   pulses_a = 0, pulses_b = 0, pulses_c = 0;
  exp_t exp_a[$], exp_b[$], exp_c[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adder_bist_controller_if #(.NBITS(4), .ERR_W(32)) if_a ();
  adder_bist_controller_if #(.NBITS(4), .ERR_W(4))  if_b ();
  adder_bist_controller_if #(.NBITS(4), .ERR_W(32)) if_c ();

  adder_bist_controller #(.NBITS(4), .SETTLE_CYCLES(1), .ERR_W(32)) u_a (
    .clk(clk), .reset_n(reset_n), .bus(if_a));
  adder_bist_controller #(.NBITS(4), .SETTLE_CYCLES(1), .ERR_W(4)) u_b (
    .clk(clk), .reset_n(reset_n), .bus(if_b));
  adder_bist_controller #(.NBITS(4), .SETTLE_CYCLES(3), .ERR_W(32)) u_c (
    .clk(clk), .reset_n(reset_n), .bus(if_c));

  logic [4:0] tru_a, tru_b, tru_c;
  assign tru_a = {1'b0, if_a.a_out} + {1'b0, if_a.b_out} + {4'b0, if_a.cin_out};
  assign tru_b = {1'b0, if_b.a_out} + {1'b0, if_b.b_out} + {4'b0, if_b.cin_out};
  assign tru_c = {1'b0, if_c.a_out} + {1'b0, if_c.b_out} + {4'b0, if_c.cin_out};

  always_comb begin
    if_a.sum_in  = tru_a[3:0];
    if_a.cout_in = tru_a[4];
    if (mode_a == 1) if_a.sum_in[0] = 1'b0;
    if (mode_a == 2) if_a.cout_in = 1'b0;
  end
  assign if_b.sum_in  = tru_b[3:0] & 4'b1110;
  assign if_b.cout_in = tru_b[4];
  assign if_c.sum_in  = tru_c[3:0];
  assign if_c.cout_in = tru_c[4];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic no_result(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: done rose with no expected result queued (cycle %0d)", name, cyc);
  endtask

  // Monitors: compare a popped expectation whenever done rises.
  logic done_a_prev = 1'b0, done_b_prev = 1'b0, done_c_prev = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (if_a.err_pulse) pulses_a++;
    if (if_a.done && !done_a_prev) begin
      if (exp_a.size() == 0) no_result("a_done");
      else begin
        e = exp_a.pop_front();
        check("a_cycles", cyc - st_a, e.cycles);
        check("a_err_count", int'(if_a.err_count), e.errs);
        check("a_err_pulses", pulses_a, e.pulses);
        check("a_pass", int'(if_a.pass), e.pass);
        check("a_first_a", int'(if_a.first_err_a), e.fa);
        check("a_first_b", int'(if_a.first_err_b), e.fb);
        check("a_first_cin", int'(if_a.first_err_cin), e.fcin);
        check("a_busy_done", int'(if_a.busy), 0);
        check("a_hold_vector", int'({if_a.cin_out, if_a.a_out, if_a.b_out}), 511);
      end
    end
    done_a_prev = if_a.done;
  end

  always @(negedge clk) begin
    exp_t e;
    if (if_b.err_pulse) pulses_b++;
    if (if_b.done && !done_b_prev) begin
      if (exp_b.size() == 0) no_result("b_done");
      else begin
        e = exp_b.pop_front();
        check("b_cycles", cyc - st_b, e.cycles);
        check("b_err_count_sat", int'(if_b.err_count), e.errs);
        check("b_err_pulses", pulses_b, e.pulses);
        check("b_pass", int'(if_b.pass), e.pass);
        check("b_first_b", int'(if_b.first_err_b), e.fb);
      end
    end
    done_b_prev = if_b.done;
  end

  always @(negedge clk) begin
    exp_t e;
    if (if_c.err_pulse) pulses_c++;
    if (if_c.done && !done_c_prev) begin
      if (exp_c.size() == 0) no_result("c_done");
      else begin
        e = exp_c.pop_front();
        check("c_cycles_settle3", cyc - st_c, e.cycles);
        check("c_err_count", int'(if_c.err_count), e.errs);
        check("c_err_pulses", pulses_c, e.pulses);
        check("c_pass", int'(if_c.pass), e.pass);
      end
    end
    done_c_prev = if_c.done;
  end

  task automatic start_pulse(input int which, input bit rec);
    @(posedge clk); #1;
    case (which)
      0:       if_a.start = 1'b1;
      1:       if_b.start = 1'b1;
      default: if_c.start = 1'b1;
    endcase
    @(posedge clk); #1;
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    if_c.start = 1'b0;
    if (rec) begin
      case (which)
        0:       begin st_a = cyc; pulses_a = 0; end
        1:       begin st_b = cyc; pulses_b = 0; end
        default: begin st_c = cyc; pulses_c = 0; end
      endcase
    end
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((exp_a.size() + exp_b.size() + exp_c.size()) != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (k >= budget) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding after %0d cycles",
               exp_a.size() + exp_b.size() + exp_c.size(), budget);
      exp_a.delete();
      exp_b.delete();
      exp_c.delete();
    end
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, "_busy"}, int'(if_a.busy), 0);
    check({tag, "_done"}, int'(if_a.done), 0);
    check({tag, "_pass"}, int'(if_a.pass), 0);
    check({tag, "_err_pulse"}, int'(if_a.err_pulse), 0);
    check({tag, "_err_count"}, int'(if_a.err_count), 0);
    check({tag, "_operands"}, int'({if_a.cin_out, if_a.a_out, if_a.b_out}), 0);
    check({tag, "_first_err"}, int'({if_a.first_err_cin, if_a.first_err_a, if_a.first_err_b}), 0);
  endtask

  initial begin
    int k;
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    if_c.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_a("reset");
    #1 reset_n = 1'b1;

    // Good adder, saturating 4-bit counter with sum[0] fault, and 3-cycle settle.
    exp_a.push_back('{1024, 0, 0, 0, 0, 0, 1});
    start_pulse(0, 1'b1);
    exp_b.push_back('{1024, 15, 256, 0, 1, 0, 0});
    start_pulse(1, 1'b1);
    exp_c.push_back('{2048, 0, 0, 0, 0, 0, 1});
    start_pulse(2, 1'b1);
    wait_drain(2500);

    // sum[0] stuck low; a second start mid-sweep must not restart it.
    mode_a = 1;
    exp_a.push_back('{1024, 256, 256, 0, 1, 0, 0});
    start_pulse(0, 1'b1);
    repeat (300) @(posedge clk);
    start_pulse(0, 1'b0);
    wait_drain(1200);

    // cout stuck low, started from DONE: previous results must clear.
    mode_a = 2;
    exp_a.push_back('{1024, 256, 256, 1, 15, 0, 0});
    start_pulse(0, 1'b1);
    @(negedge clk);
    check("restart_done", int'(if_a.done), 0);
    check("restart_busy", int'(if_a.busy), 1);
    check("restart_err_count", int'(if_a.err_count), 0);
    check("restart_first_err", int'({if_a.first_err_a, if_a.first_err_b}), 0);
    k = 0;
    while (!if_a.cin_out && k < 1200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 1200) begin
      n_tests++;
      n_fail++;
      $display("FAIL cin_wait_timeout: cin_out never rose within %0d cycles", k);
    end else begin
      check("errs_at_cin0_end", int'(if_a.err_count), 120);
    end
    wait_drain(1200);

    // Reset mid-sweep aborts everything; a fresh sweep then runs clean.
    mode_a = 1;
    start_pulse(0, 1'b1);
    repeat (100) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check_zero_a("midreset");
    mode_a = 0;
    exp_a.push_back('{1024, 0, 0, 0, 0, 0, 1});
    start_pulse(0, 1'b1);
    wait_drain(1200);

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
